axi_lite_bus_master: RTL and testbench
======================================

AXI_LITE_BUS_MASTER -- requirements
Module: axi_lite_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: response-timeout limit in clk cycles, used only with AXI_TIMEOUT_EN.
REQ-002 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  converted CPU request present (address type AXI).
- req_ready  out  1  request accepted when req_valid and req_ready are both 1.
- req_is_read  in  1  1 = read, 0 = write.
- req_addr  in  32  byte address on the AXI map.
- req_wdata  in  32  write data, lane-replicated by the converter.
- req_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; 0 for writes.
- rsp_err  out  1  slave, decode or timeout error.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  AXI4-Lite AW channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  AR channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel.

Function
REQ-004 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP, and allow at most one outstanding transaction.
REQ-005 SHALL drive req_ready=1 only in IDLE; on acceptance it SHALL latch addr, wdata, wstrb and is_read, then move to RD_ADDR (read) or WR_ADDR_DATA (write).
REQ-006 SHALL tie awprot and arprot to 3'b000, and drive awaddr and araddr from the latched address.
REQ-007 In RD_ADDR, SHALL hold arvalid=1 until arready, then move to RD_DATA.
REQ-008 In RD_DATA, SHALL hold rready=1; on rvalid it SHALL capture rdata[8*addr[1:0] +: 8] into rsp_rdata, set rsp_err=rresp[1], and move to RESP.
REQ-009 In WR_ADDR_DATA, SHALL raise awvalid and wvalid in the same cycle and drop each independently on its own handshake; once both have completed (in either order or the same cycle) it SHALL move to WR_RESP.
REQ-010 In WR_RESP, SHALL hold bready=1; on bvalid it SHALL set rsp_err=bresp[1], set rsp_rdata=0, and move to RESP.
REQ-011 In RESP, SHALL pulse rsp_valid for exactly one cycle, then return to IDLE.
REQ-012 rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-013 SHALL keep each valid asserted and its payload stable until the matching ready is seen (no AXI valid withdrawal).
REQ-014 Minimum latency with all readys and responses in the earliest cycle: accept in cycle T, read rsp_valid at T+3, write rsp_valid at T+3.
REQ-015 A new request SHALL NOT be accepted before the cycle after rsp_valid, because req_ready is 0 in RESP.

Reset
REQ-016 On reset the block SHALL enter IDLE and drive all AXI valid and ready outputs to 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction at the next edge with no rsp_valid; req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-018 With macro AXI_TIMEOUT_EN defined, a counter SHALL clear on acceptance and increment each cycle in RD_ADDR, RD_DATA, WR_ADDR_DATA and WR_RESP.
REQ-019 With AXI_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL deassert all AXI valid and ready outputs and enter RESP with rsp_err=1 and rsp_rdata=8'hFF.
REQ-020 Without AXI_TIMEOUT_EN, SHALL contain no counter logic, SHALL wait indefinitely for responses, and SHALL ignore TIMEOUT_CYCLES.

Verification
REQ-021 Read: addr=0x8000_0002, rdata=0xAABBCCDD, rresp=0, zero-wait slave -> rsp_valid at T+3, rsp_rdata=0xBB, rsp_err=0.
REQ-022 Write: addr=0x8000_0003, wdata=0x5A5A5A5A, wstrb=4'b1000; awready two cycles after wready -> single AW and single W handshake, bresp=0 gives rsp_err=0 and rsp_rdata=0.
REQ-023 Error: read with rresp=2'b11 -> rsp_err=1; write with bresp=2'b10 -> rsp_err=1.
REQ-024 Backpressure: arready held low 5 cycles -> arvalid and araddr stable throughout, req_ready=0, exactly one rsp_valid.
REQ-025 Reset asserted in RD_DATA -> arvalid and rready are 0 next cycle, no rsp_valid, req_ready=1 after reset.
REQ-026 With AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts bvalid -> rsp_valid with rsp_err=1 and rsp_rdata=8'hFF, then IDLE.

Source files
------------

// File: rtl/axi_lite_bus_master.sv
// Single-outstanding AXI4-Lite master: one request in, one read byte or write status out.
// Optional response timeout guarded by macro AXI_TIMEOUT_EN (TIMEOUT_CYCLES ignored without it).
module axi_lite_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_read,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        is_read_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [7:0]  rsp_rdata_q;
  logic [7:0]  rd_byte_d;
  logic        aw_done_d, w_done_d;
  logic        tmo_hit_d;

  assign rd_byte_d = 8'(m_axi_rdata >> {addr_q[1:0], 3'b000});
  assign aw_done_d = !awvalid_q || m_axi_awready;
  assign w_done_d  = !wvalid_q  || m_axi_wready;

`ifdef AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          busy_d;
  assign busy_d    = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                     (state_q == WR_ADDR_DATA) || (state_q == WR_RESP);
  assign tmo_hit_d = busy_d && (tmo_cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset)
      tmo_cnt_q <= '0;
    else if (state_q == IDLE && req_valid)
      tmo_cnt_q <= '0;
    else if (busy_d && !tmo_hit_d)
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      is_read_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          wstrb_q   <= req_wstrb;
          is_read_q <= req_is_read;
          if (req_is_read) begin
            arvalid_q <= 1'b1;
            state_q   <= RD_ADDR;
          end else begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR_ADDR_DATA;
          end
        end
        RD_ADDR: if (m_axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (m_axi_rvalid) begin
          rready_q    <= 1'b0;
          rsp_rdata_q <= rd_byte_d;
          rsp_err_q   <= m_axi_rresp[1];
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        WR_ADDR_DATA: begin
          // AW and W complete independently; leave once both are done.
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (m_axi_bvalid) begin
          bready_q    <= 1'b0;
          rsp_err_q   <= m_axi_bresp[1];
          rsp_rdata_q <= 8'h00;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (tmo_hit_d) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= 8'hFF;
        rsp_valid_q <= 1'b1;
        state_q     <= RESP;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{m_axi_rresp[0], m_axi_bresp[0], is_read_q};

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_bus_master.sv
// Scoreboard bench for axi_lite_bus_master with a reactive, delay-programmable AXI-Lite slave.
module tb_axi_lite_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_is_read = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  axi_lite_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_read(req_is_read),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, rsp_cnt = 0;
  int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0;
  bit b_never = 1'b0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    bit         chk_lat;
    int         t;
    string      name;
  } exp_t;
  exp_t sb[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: each ready/valid rises after a programmable number of cycles of demand.
  initial forever begin
    @(negedge clk);
    m_axi_rdata = m_axi_rdata;
    if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_wait); ar_cnt++; end
    else begin m_axi_arready = 1'b0; ar_cnt = 0; end
    if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_wait); aw_cnt++; end
    else begin m_axi_awready = 1'b0; aw_cnt = 0; end
    if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_wait); w_cnt++; end
    else begin m_axi_wready = 1'b0; w_cnt = 0; end
    if (m_axi_rready) begin m_axi_rvalid = (r_cnt >= r_wait); r_cnt++; end
    else begin m_axi_rvalid = 1'b0; r_cnt = 0; end
    m_axi_bvalid = m_axi_bready && !b_never;
    if (!reset) begin
      if (m_axi_arvalid && m_axi_arready) begin ar_hs++; last_araddr = m_axi_araddr; end
      if (m_axi_awvalid && m_axi_awready) begin aw_hs++; last_awaddr = m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
      end
    end
  end

  // Monitor: every rsp_valid pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (!reset && rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        check({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
        if (e.chk_lat) check({e.name, "_latency"}, 64'(cyc - e.t), 64'd3);
      end
    end
  end

  task automatic issue(bit rd, logic [31:0] addr, logic [31:0] wd, logic [3:0] strb,
                       logic [7:0] er, logic ee, bit chk, string name);
    exp_t e;
    int n = 0;
    @(negedge clk);
    req_is_read = rd; req_addr = addr; req_wdata = wd; req_wstrb = strb; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check({name, "_accept"}, 64'(req_ready), 64'd1);
    e.rdata = er; e.err = ee; e.chk_lat = chk; e.t = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check({name, "_done"}, 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int rc;
    m_axi_rdata = 32'hAABBCCDD;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, rsp_valid, rsp_rdata, rsp_err,
                             m_axi_awprot, m_axi_arprot}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);

    issue(1'b1, 32'h8000_0002, '0, '0, 8'hBB, 1'b0, 1'b1, "rd_lane2");
    wait_done("rd_lane2");
    check("rd_araddr", 64'(last_araddr), 64'h8000_0002);
    issue(1'b1, 32'h8000_0000, '0, '0, 8'hDD, 1'b0, 1'b1, "rd_lane0");
    wait_done("rd_lane0");
    issue(1'b1, 32'h8000_0003, '0, '0, 8'hAA, 1'b0, 1'b1, "rd_lane3");
    wait_done("rd_lane3");
    issue(1'b0, 32'h0000_0010, 32'h1234_5678, 4'b1111, 8'h00, 1'b0, 1'b1, "wr_zero_wait");
    wait_done("wr_zero_wait");

    aw_wait = 2; w_wait = 0; aw_hs = 0; w_hs = 0;
    issue(1'b0, 32'h8000_0003, 32'h5A5A_5A5A, 4'b1000, 8'h00, 1'b0, 1'b0, "wr_aw_late");
    wait_done("wr_aw_late");
    check("wr_aw_hs", 64'(aw_hs), 64'd1);
    check("wr_w_hs", 64'(w_hs), 64'd1);
    check("wr_awaddr", 64'(last_awaddr), 64'h8000_0003);
    check("wr_wdata", 64'(last_wdata), 64'h5A5A_5A5A);
    check("wr_wstrb", 64'(last_wstrb), 64'h8);
    aw_wait = 0;

    m_axi_rresp = 2'b11;
    issue(1'b1, 32'h8000_0001, '0, '0, 8'hCC, 1'b1, 1'b1, "rd_slverr");
    wait_done("rd_slverr");
    m_axi_rresp = 2'b00;
    m_axi_bresp = 2'b10;
    issue(1'b0, 32'h8000_0004, 32'h0, 4'b0001, 8'h00, 1'b1, 1'b1, "wr_slverr");
    wait_done("wr_slverr");
    m_axi_bresp = 2'b00;

    ar_wait = 5;
    rc = rsp_cnt;
    issue(1'b1, 32'h1234_5670, '0, '0, 8'hDD, 1'b0, 1'b0, "rd_backpressure");
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", 64'({m_axi_arvalid, m_axi_araddr, req_ready}),
            64'({1'b1, 32'h1234_5670, 1'b0}));
      @(negedge clk);
    end
    wait_done("rd_backpressure");
    check("bp_one_rsp", 64'(rsp_cnt - rc), 64'd1);
    ar_wait = 0;

    r_wait = 1000;
    issue(1'b1, 32'h8000_0000, '0, '0, 8'h00, 1'b0, 1'b0, "rd_reset");
    n = 0;
    while (!m_axi_rready && n < 50) begin @(negedge clk); n++; end
    check("rst_reach_rd_data", 64'(m_axi_rready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_outs", 64'({m_axi_arvalid, m_axi_rready, rsp_valid}), 64'd0);
    sb.delete();
    r_wait = 0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    issue(1'b1, 32'h8000_0002, '0, '0, 8'hBB, 1'b0, 1'b1, "rd_after_reset");
    wait_done("rd_after_reset");

`ifdef AXI_TIMEOUT_EN
    b_never = 1'b1;
    issue(1'b0, 32'h8000_0008, 32'hFFFF_FFFF, 4'b1111, 8'hFF, 1'b1, 1'b0, "wr_timeout");
    wait_done("wr_timeout");
    b_never = 1'b0;
    check("tmo_idle", 64'({req_ready, m_axi_bready}), 64'h2);
    issue(1'b1, 32'h8000_0001, '0, '0, 8'hCC, 1'b0, 1'b1, "rd_after_timeout");
    wait_done("rd_after_timeout");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
